// File: rtl/updown_mod_counter.sv
// Up/down counter with programmable limit, variable step, wrap/saturate mode and prescaler.
// Optional capture register enabled by defining COUNTER_CAPTURE_EN.
module updown_mod_counter #(
  parameter int N       = 8,
  parameter int STEP_W  = 4,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               load,
  input  logic [N-1:0]       d,
  input  logic               lim_we,
  input  logic [N-1:0]       lim_d,
  input  logic               en,
  input  logic               up,
  input  logic [STEP_W-1:0]  step,
  input  logic               mode,
  input  logic [PRESC_W-1:0] div,
  output logic [N-1:0]       q,
  output logic [N-1:0]       limit,
  output logic               max_tick,
  output logic               min_tick,
  output logic               wrap
`ifdef COUNTER_CAPTURE_EN
  ,
  input  logic               capture,
  output logic [N-1:0]       cap_q
`endif
);

  logic [PRESC_W-1:0] pc, pc_n;
  logic [N-1:0]       q_n, limit_n, step_n;
  logic [N:0]         sum;
  logic               wrap_n, fire;

  assign step_n = N'(step);
  // Extra bit keeps q + step from truncating before the limit compare.
  assign sum    = {1'b0, q} + {1'b0, step_n};

  always_comb begin
    q_n     = q;
    limit_n = limit;
    pc_n    = pc;
    wrap_n  = 1'b0;
    fire    = 1'b0;

    if (lim_we)
      limit_n = lim_d;

    if (clr) begin
      q_n  = '0;
      pc_n = '0;
    end else if (load) begin
      q_n  = (d < limit_n) ? d : limit_n;
      pc_n = '0;
    end else if (lim_we) begin
      q_n  = (q < lim_d) ? q : lim_d;
    end else if (en) begin
      // pc > div after a div change must still fire rather than run past.
      if (pc >= div) begin
        pc_n = '0;
        fire = 1'b1;
      end else begin
        pc_n = pc + PRESC_W'(1);
      end
    end

    if (fire) begin
      if (up) begin
        if (sum <= {1'b0, limit}) begin
          q_n = sum[N-1:0];
        end else begin
          q_n    = mode ? limit : '0;
          wrap_n = 1'b1;
        end
      end else begin
        if (q >= step_n) begin
          q_n = q - step_n;
        end else begin
          q_n    = mode ? '0 : limit;
          wrap_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      limit <= '1;
      pc    <= '0;
      wrap  <= 1'b0;
    end else begin
      q     <= q_n;
      limit <= limit_n;
      pc    <= pc_n;
      wrap  <= wrap_n;
    end
  end

  assign max_tick = (q == limit);
  assign min_tick = (q == '0);

`ifdef COUNTER_CAPTURE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cap_q <= '0;
    else if (capture)
      cap_q <= q;
  end
`endif

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down counter with programmable limit (modulus), variable step, wrap or saturate mode, and a clock-enable prescaler. It generalises the team's fixed-width free-running counter for timer, baud and frame-position uses. It sits in datapath and control blocks wherever a bounded, loadable count with terminal-count flags is needed.

## Interface
- N, 8, counter width (≥2)
- STEP_W, 4, width of step input (STEP_W ≤ N)
- PRESC_W, 8, width of prescaler divide input

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clr  in  1  synchronous clear of count and prescaler
- load  in  1  synchronous load of d
- d  in  N  load value
- lim_we  in  1  write strobe for limit register
- lim_d  in  N  new limit value
- en  in  1  count enable (qualified by prescaler)
- up  in  1  1 = count up, 0 = count down
- step  in  STEP_W  increment/decrement magnitude
- mode  in  1  0 = wrap, 1 = saturate
- div  in  PRESC_W  prescaler: step every div+1 enabled cycles
- q  out  N  current count
- limit  out  N  current limit register
- max_tick  out  1  q == limit (combinational from registers)
- min_tick  out  1  q == 0 (combinational from registers)
- wrap  out  1  registered one-cycle pulse: wrap or saturation event occurred on this edge

## Operation
- Reset: q = 0, limit = 2^N−1, prescaler count pc = 0, wrap = 0; hence min_tick = 1, max_tick = 0.
- Per-edge priority: clr > load > lim_we > count > hold.
- clr: q ← 0, pc ← 0, wrap ← 0. limit unaffected.
- load: q ← min(d, limit), pc ← 0, wrap ← 0.
- lim_we: limit ← lim_d; q ← min(q, lim_d); no counting this cycle; pc holds. lim_we with clr or load: limit still written; clr/load applies to q, and load clamps against the new limit.
- Prescaler: with en = 1, pc increments each cycle; when pc == div, pc ← 0 and a step fires. div = 0 gives a step on every enabled cycle. en = 0 holds pc and q. A div change takes effect on the next compare. If pc > div, the next enabled cycle fires and pc ← 0.
- Step arithmetic uses N+1 bits with no truncation.
  - Up: s = q + step. If s ≤ limit, q ← s. Otherwise wrap mode gives q ← 0 and saturate mode gives q ← limit; wrap ← 1 in both cases.
  - Down: if q ≥ step, q ← q − step. Otherwise wrap mode gives q ← limit and saturate mode gives q ← 0; wrap ← 1.
  - Saturate mode already at the bound (q == limit up, or q == 0 down) with step ≠ 0: q holds and wrap ← 1 on every fired step.
  - step = 0: a fired step leaves q unchanged and wrap = 0.
- limit = 0: q stays 0. Every nonzero fired step sets wrap ← 1. max_tick = min_tick = 1.
- wrap is 0 on every edge that does not fire an overflowing or underflowing step.

## Timing
- Registers: q, limit, pc, wrap (and cap_q), all updated on the rising clk edge.
- Latency: input to q, limit or wrap is 1 cycle. max_tick and min_tick follow q and limit with no added latency.
- reset is asynchronous assert. Deassertion is synchronised externally. Asserting reset mid-count forces the reset values immediately.
- There is no handshake. All control inputs are sampled every edge.

## Configuration
- Macro COUNTER_CAPTURE_EN.
- Defined: adds input `capture` (1) and output `cap_q` (N). When capture = 1, cap_q ← q value before this edge's update; otherwise it holds. Reset gives cap_q = 0. Capture is independent of clr, load and lim_we priority.
- Undefined: ports and register are absent, and behaviour is otherwise identical.

## Test plan
- Reset and basic count: reset, then en = 1, up = 1, step = 1, div = 0, limit = 9, wrap mode for 12 cycles. Required: q = 1..9, 0, 1, 2; wrap is high only on the 9→0 edge; max_tick is high while q = 9.
- Saturate down with step: load d = 5, mode = 1, up = 0, step = 2. Required: q = 3, 1, 0, 0. wrap is high on the 1→0 edge and on each following fired step.
- Prescaler: div = 3, step = 1, en = 1 for 8 cycles from q = 0. Required: q = 1 at cycle 4 and q = 2 at cycle 8. With en = 0 for 2 cycles mid-sequence, q and pc hold.
- Limit shrink and load clamp: q = 200, lim_we with lim_d = 50 gives q = 50 and max_tick = 1. Then load with d = 120 gives q = 50.
- Priority: assert clr, load and en together at q = 7. Required: q = 0, pc = 0, wrap = 0. Assert load and en at q = 7 with d = 3. Required: q = 3.
- Capture (COUNTER_CAPTURE_EN defined): counting up at q = 4, pulse capture. Required: cap_q = 4 and q = 5 after the edge. A mid-count reset gives q = 0, cap_q = 0 and limit = 255 (N = 8).
